// File: rtl/mdu_issue_ctrl_if.sv
// Signal bundle between the EX stage / multiplier / divider and the M-extension issue controller.
// The slave modport is the controller's view; the master modport is the surrounding pipeline and datapath.
interface mdu_issue_ctrl_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5
);
    logic            MDU_VALID;
    logic [2:0]      MDU_FUNCT3;
    logic [XLEN-1:0] RS1_DATA;
    logic [XLEN-1:0] RS2_DATA;
    logic [REGW-1:0] RD_ADDR;
    logic            FLUSH;
    logic [XLEN-1:0] OPER_A;
    logic [XLEN-1:0] OPER_B;
    logic            ENABLE_MULT;
    logic            FUCT3;
    logic [XLEN-1:0] MULT_O;
    logic            MULT_FINISH;
    logic            ENABLE_DIV;
    logic            DIV_SIGNED;
    logic [XLEN-1:0] DIV_QUOT;
    logic [XLEN-1:0] DIV_REM;
    logic            DIV_FINISH;
    logic            MDU_STALL;
    logic [XLEN-1:0] MDU_RESULT;
    logic [REGW-1:0] MDU_RD;
    logic            MDU_WB_VALID;

    modport slave (
        input  MDU_VALID, MDU_FUNCT3, RS1_DATA, RS2_DATA, RD_ADDR, FLUSH,
        input  MULT_O, MULT_FINISH, DIV_QUOT, DIV_REM, DIV_FINISH,
        output OPER_A, OPER_B, ENABLE_MULT, FUCT3, ENABLE_DIV, DIV_SIGNED,
        output MDU_STALL, MDU_RESULT, MDU_RD, MDU_WB_VALID
    );

    modport master (
        output MDU_VALID, MDU_FUNCT3, RS1_DATA, RS2_DATA, RD_ADDR, FLUSH,
        output MULT_O, MULT_FINISH, DIV_QUOT, DIV_REM, DIV_FINISH,
        input  OPER_A, OPER_B, ENABLE_MULT, FUCT3, ENABLE_DIV, DIV_SIGNED,
        input  MDU_STALL, MDU_RESULT, MDU_RD, MDU_WB_VALID
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// RV32M issue sequencer: latches an op, runs the multiplier or divider, fixes up
// unsigned high products and divide corner cases, and emits a one-cycle writeback.
//
// state   | meaning
// IDLE    | waiting for an op from EX
// MUL_RUN | multiplier running, waiting on MULT_FINISH
// DIV_RUN | divider running, waiting on DIV_FINISH
// CORR    | signed-to-unsigned high-word correction (MULHSU/MULHU)
// DONE    | writeback strobe cycle
module mdu_issue_ctrl #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input logic            CLK,
    input logic            RST,
    mdu_issue_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_RUN = 3'd1,
        DIV_RUN = 3'd2,
        CORR    = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] oper_a;
    logic [XLEN-1:0] oper_b;
    logic [2:0]      f3_q;
    logic [REGW-1:0] rd_q;
    logic [XLEN-1:0] result_q;
    logic            fuct3_q;
    logic            div_signed_q;

    logic            b_zero;
    logic            div_ovf;
    logic [XLEN-1:0] corr_add;

    assign b_zero  = (bus.RS2_DATA == '0);
    assign div_ovf = ~bus.MDU_FUNCT3[0] && (bus.RS1_DATA == MIN_INT) && (bus.RS2_DATA == '1);

    // The multiplier only produces signed x signed high words; add back the
    // operand terms that the unsigned interpretation contributes.
    always_comb begin
        corr_add = oper_b[XLEN-1] ? oper_a : '0;
        if (f3_q[0])
            corr_add = corr_add + (oper_a[XLEN-1] ? oper_b : '0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.MDU_VALID) begin
                    if (!bus.MDU_FUNCT3[2])
                        state_nxt = MUL_RUN;
                    else if (b_zero || div_ovf)
                        state_nxt = DONE;
                    else
                        state_nxt = DIV_RUN;
                end
            end
            MUL_RUN: if (bus.MULT_FINISH) state_nxt = f3_q[1] ? CORR : DONE;
            DIV_RUN: if (bus.DIV_FINISH) state_nxt = DONE;
            CORR:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.FLUSH)
            state_nxt = IDLE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            oper_a       <= '0;
            oper_b       <= '0;
            f3_q         <= '0;
            rd_q         <= '0;
            result_q     <= '0;
            fuct3_q      <= 1'b0;
            div_signed_q <= 1'b0;
        end else if (!bus.FLUSH) begin
            case (state)
                IDLE: begin
                    if (bus.MDU_VALID) begin
                        oper_a <= bus.RS1_DATA;
                        oper_b <= bus.RS2_DATA;
                        f3_q   <= bus.MDU_FUNCT3;
                        rd_q   <= bus.RD_ADDR;
                        if (!bus.MDU_FUNCT3[2])
                            fuct3_q <= (bus.MDU_FUNCT3 != 3'b000);
                        else if (b_zero)
                            result_q <= bus.MDU_FUNCT3[1] ? bus.RS1_DATA : '1;
                        else if (div_ovf)
                            result_q <= bus.MDU_FUNCT3[1] ? '0 : MIN_INT;
                        else
                            div_signed_q <= ~bus.MDU_FUNCT3[0];
                    end
                end
                MUL_RUN: if (bus.MULT_FINISH) result_q <= bus.MULT_O;
                DIV_RUN: if (bus.DIV_FINISH) result_q <= f3_q[1] ? bus.DIV_REM : bus.DIV_QUOT;
                CORR:    result_q <= result_q + corr_add;
                default: ;
            endcase
        end
    end

    assign bus.OPER_A       = oper_a;
    assign bus.OPER_B       = oper_b;
    assign bus.ENABLE_MULT  = (state == MUL_RUN);
    assign bus.FUCT3        = fuct3_q;
    assign bus.ENABLE_DIV   = (state == DIV_RUN);
    assign bus.DIV_SIGNED   = div_signed_q;
    assign bus.MDU_RESULT   = result_q;
    assign bus.MDU_RD       = rd_q;
    assign bus.MDU_WB_VALID = (state == DONE);
    assign bus.MDU_STALL    = ((state == IDLE) && bus.MDU_VALID && !bus.FLUSH)
                            || (state == MUL_RUN) || (state == DIV_RUN) || (state == CORR);
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl with hand-computed expected results;
// the multiplier and divider are stubbed by the stimulus itself.
module tb_mdu_issue_ctrl;
    logic CLK;
    logic RST;
    int   errors = 0;
    int   checks = 0;

    mdu_issue_ctrl_if #(.XLEN(32), .REGW(5)) bus ();

    mdu_issue_ctrl #(.XLEN(32), .REGW(5)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
        bus.MDU_VALID  = 1'b1;
        bus.MDU_FUNCT3 = f3;
        bus.RS1_DATA   = a;
        bus.RS2_DATA   = b;
        bus.RD_ADDR    = rd;
    endtask

    // Multiplier op: stub answers with resp after three enabled cycles.
    task automatic mul_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] resp,
                          input int exp_lat, input logic [31:0] exp_res);
        int n;
        drive_op(f3, a, b, rd);
        #1;
        check({tag, "_stall_acc"}, 32'(bus.MDU_STALL), 32'd1);
        step();
        bus.MDU_VALID = 1'b0;
        check({tag, "_en"}, 32'(bus.ENABLE_MULT), 32'd1);
        check({tag, "_fuct3"}, 32'(bus.FUCT3), 32'(f3 != 3'b000));
        check({tag, "_opa"}, bus.OPER_A, a);
        step();
        step();
        bus.MULT_O      = resp;
        bus.MULT_FINISH = 1'b1;
        step();
        bus.MULT_FINISH = 1'b0;
        n = 3;
        while (!bus.MDU_WB_VALID && n < 20) begin
            step();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_res"}, bus.MDU_RESULT, exp_res);
        check({tag, "_rd"}, 32'(bus.MDU_RD), 32'(rd));
        check({tag, "_stall_done"}, 32'(bus.MDU_STALL), 32'd0);
        check({tag, "_en_done"}, 32'(bus.ENABLE_MULT), 32'd0);
        step();
        check({tag, "_wb_once"}, 32'(bus.MDU_WB_VALID), 32'd0);
        check({tag, "_hold"}, bus.MDU_RESULT, exp_res);
    endtask

    // Divide special cases complete one cycle after accept without the divider.
    task automatic div_special(input string tag, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_res);
        drive_op(f3, a, b, 5'd9);
        step();
        bus.MDU_VALID = 1'b0;
        check({tag, "_wb"}, 32'(bus.MDU_WB_VALID), 32'd1);
        check({tag, "_div_en"}, 32'(bus.ENABLE_DIV), 32'd0);
        check({tag, "_res"}, bus.MDU_RESULT, exp_res);
        step();
        check({tag, "_div_en2"}, 32'(bus.ENABLE_DIV), 32'd0);
    endtask

    task automatic div_op(input string tag, input logic [2:0] f3, input logic [31:0] exp_res);
        int signed_seen;
        drive_op(f3, 32'd100, 32'd7, 5'd12);
        step();
        bus.MDU_VALID = 1'b0;
        check({tag, "_en"}, 32'(bus.ENABLE_DIV), 32'd1);
        signed_seen = 0;
        for (int i = 0; i < 9; i++) begin
            if (bus.DIV_SIGNED !== 1'b0 || bus.MDU_WB_VALID !== 1'b0) signed_seen++;
            step();
        end
        bus.DIV_QUOT   = 32'd14;
        bus.DIV_REM    = 32'd2;
        bus.DIV_FINISH = 1'b1;
        step();
        bus.DIV_FINISH = 1'b0;
        check({tag, "_signed"}, 32'(signed_seen), 32'd0);
        check({tag, "_wb"}, 32'(bus.MDU_WB_VALID), 32'd1);
        check({tag, "_res"}, bus.MDU_RESULT, exp_res);
        check({tag, "_en_done"}, 32'(bus.ENABLE_DIV), 32'd0);
        step();
    endtask

    initial begin
        RST             = 1'b1;
        bus.MDU_VALID   = 1'b0;
        bus.MDU_FUNCT3  = 3'b000;
        bus.RS1_DATA    = '0;
        bus.RS2_DATA    = '0;
        bus.RD_ADDR     = '0;
        bus.FLUSH       = 1'b0;
        bus.MULT_O      = '0;
        bus.MULT_FINISH = 1'b0;
        bus.DIV_QUOT    = '0;
        bus.DIV_REM     = '0;
        bus.DIV_FINISH  = 1'b0;
        #12;
        check("rst_res", bus.MDU_RESULT, 32'd0);
        check("rst_wb", 32'(bus.MDU_WB_VALID), 32'd0);
        check("rst_stall", 32'(bus.MDU_STALL), 32'd0);
        check("rst_en", 32'({bus.ENABLE_MULT, bus.ENABLE_DIV, bus.FUCT3, bus.DIV_SIGNED}), 32'd0);
        RST = 1'b0;
        step();

        mul_op("mul", 3'b000, 32'd234, 32'd277, 5'd5, 32'h0000FD32, 3, 32'h0000FD32);
        mul_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'h0, 4, 32'hFFFFFFFE);
        mul_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'h0, 4, 32'hFFFFFFFF);
        mul_op("mulh", 3'b001, 32'hFFFFFFF8, 32'hFFFFFFFD, 5'd8, 32'h0, 3, 32'h00000000);

        div_special("div0", 3'b100, 32'd7, 32'd0, 32'hFFFFFFFF);
        div_special("remu0", 3'b111, 32'd7, 32'd0, 32'd7);
        div_special("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        div_special("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);

        div_op("divu", 3'b101, 32'd14);
        div_op("remu", 3'b111, 32'd2);

        // Flush three cycles into the multiply; a late finish must be ignored.
        drive_op(3'b000, 32'd5, 32'd6, 5'd3);
        step();
        bus.MDU_VALID = 1'b0;
        step();
        step();
        bus.FLUSH = 1'b1;
        step();
        bus.FLUSH = 1'b0;
        check("flush_en", 32'(bus.ENABLE_MULT), 32'd0);
        check("flush_stall", 32'(bus.MDU_STALL), 32'd0);
        check("flush_wb", 32'(bus.MDU_WB_VALID), 32'd0);
        bus.MULT_O      = 32'hDEADBEEF;
        bus.MULT_FINISH = 1'b1;
        step();
        bus.MULT_FINISH = 1'b0;
        check("flush_late_wb", 32'(bus.MDU_WB_VALID), 32'd0);
        check("flush_keep", bus.MDU_RESULT, 32'd2);
        step();
        check("flush_late_wb2", 32'(bus.MDU_WB_VALID), 32'd0);
        mul_op("mul38", 3'b000, 32'd3, 32'd8, 5'd4, 32'd24, 3, 32'd24);

        // Asynchronous reset in the middle of a signed divide.
        drive_op(3'b100, 32'd100, 32'd7, 5'd11);
        step();
        bus.MDU_VALID = 1'b0;
        check("pre_rst_div_en", 32'(bus.ENABLE_DIV), 32'd1);
        check("pre_rst_signed", 32'(bus.DIV_SIGNED), 32'd1);
        step();
        #2;
        RST = 1'b1;
        #1;
        check("arst_div_en", 32'(bus.ENABLE_DIV), 32'd0);
        check("arst_signed", 32'(bus.DIV_SIGNED), 32'd0);
        check("arst_stall", 32'(bus.MDU_STALL), 32'd0);
        check("arst_res", bus.MDU_RESULT, 32'd0);
        check("arst_opers", bus.OPER_A | bus.OPER_B, 32'd0);
        check("arst_rd", 32'(bus.MDU_RD), 32'd0);
        #1;
        RST = 1'b0;
        step();
        check("post_rst_idle", 32'({bus.ENABLE_DIV, bus.MDU_STALL, bus.MDU_WB_VALID}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
Upstream sequencer for the M-extension datapath. It accepts a decoded RV32M op from the EX stage, latches the operands, and drives mult_radix8_top (OPER_A/OPER_B/ENABLE_MULT/FUCT3, waits on MULT_FINISH) or the sequential divider (ENABLE_DIV, waits on DIV_FINISH). It stalls the pipeline while busy, resolves divide special cases locally, applies the MULHSU/MULHU sign correction, and issues a one-cycle writeback.

Parameters:
XLEN, 32, operand/result width
REGW, 5, destination register address width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
MDU_VALID  in  1  EX stage presents an M-ext op
MDU_FUNCT3  in  3  RV32M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU)
RS1_DATA  in  XLEN  operand a
RS2_DATA  in  XLEN  operand b
RD_ADDR  in  REGW  destination register
FLUSH  in  1  abort in-flight op
OPER_A  out  XLEN  latched a to multiplier/divider
OPER_B  out  XLEN  latched b to multiplier/divider
ENABLE_MULT  out  1  multiplier run request
FUCT3  out  1  multiplier word select: 0 low word, 1 high word (signed x signed)
MULT_O  in  XLEN  multiplier result
MULT_FINISH  in  1  multiplier done
ENABLE_DIV  out  1  divider run request
DIV_SIGNED  out  1  1 for DIV/REM
DIV_QUOT  in  XLEN  quotient
DIV_REM  in  XLEN  remainder
DIV_FINISH  in  1  divider done
MDU_STALL  out  1  freeze upstream pipeline
MDU_RESULT  out  XLEN  writeback data
MDU_RD  out  REGW  writeback register
MDU_WB_VALID  out  1  one-cycle writeback strobe

Behaviour:
- Reset (async, any state): state IDLE. ENABLE_MULT, ENABLE_DIV, FUCT3, DIV_SIGNED, MDU_WB_VALID = 0. OPER_A, OPER_B, MDU_RESULT = 0. MDU_RD = 0. The in-flight op is discarded.
- States: IDLE, MUL_RUN, DIV_RUN, CORR, DONE.
- IDLE with MDU_VALID=1 and FLUSH=0: latch a, b, funct3 and rd at the edge.
  - funct3[2]=0: go to MUL_RUN. FUCT3 = (funct3 != 000).
  - funct3[2]=1, b==0: go to DONE. Result is 0xFFFFFFFF for DIV/DIVU, a for REM/REMU.
  - DIV/REM with a==0x80000000 and b==0xFFFFFFFF: go to DONE. Result is 0x80000000 for DIV, 0 for REM.
  - Any other divide: go to DIV_RUN. DIV_SIGNED = ~funct3[0].
- MUL_RUN: ENABLE_MULT=1, operands held stable.
  - On MULT_FINISH=1, capture MULT_O and drop ENABLE_MULT.
  - Go to CORR for MULHSU/MULHU; otherwise go to DONE.
- CORR, one cycle, modulo 2^32:
  - MULHU: result = MULT_O + (a[31] ? b : 0) + (b[31] ? a : 0).
  - MULHSU: result = MULT_O + (b[31] ? a : 0).
  - Then go to DONE.
- DIV_RUN: ENABLE_DIV=1. On DIV_FINISH=1, capture DIV_QUOT (funct3[1]=0) or DIV_REM (funct3[1]=1), drop ENABLE_DIV, go to DONE.
- DONE: MDU_WB_VALID=1 for exactly one cycle with MDU_RESULT/MDU_RD valid, then go to IDLE. MDU_RESULT holds its value afterwards.
- MDU_STALL is combinational: (IDLE & MDU_VALID & ~FLUSH) | MUL_RUN | DIV_RUN | CORR. It is low in DONE, so the EX stage advances in the writeback cycle.
- Latency from accept edge to WB strobe:
  - MUL/MULH: finish + 1.
  - MULHSU/MULHU: finish + 2.
  - Divide special cases: exactly 1 cycle.
- FLUSH=1 in any state wins over everything except reset. At the next edge: go to IDLE, enables drop, no WB strobe, result register unchanged.
- MULT_FINISH and DIV_FINISH are ignored outside their run state.
- MDU_VALID is ignored outside IDLE. No new op is accepted in DONE.

Test Plan:
- MUL: a=234, b=277. ENABLE_MULT rises the cycle after accept; FUCT3=0. On finish: MDU_RESULT=0x0000FD32, WB strobe one cycle, MDU_RD echoed, stall drops in DONE.
- MULHU: a=b=0xFFFFFFFF, multiplier returns MULH=0. After CORR: MDU_RESULT=0xFFFFFFFE. MULHSU with same operands: 0xFFFFFFFF. MULH(-8, -3) returns 0x00000000 with no CORR cycle.
- DIV 7/0 → 0xFFFFFFFF; REMU 7/0 → 7; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of same → 0. In all four cases ENABLE_DIV never asserts and the WB strobe comes 1 cycle after accept.
- DIVU 100/7 with divider stub returning Q=14, R=2 after 10 cycles: DIVU → 14, REMU → 2. DIV_SIGNED=0 throughout.
- FLUSH asserted 3 cycles into MUL_RUN: ENABLE_MULT=0 next cycle, no WB strobe, and a late MULT_FINISH is ignored. A subsequent MUL 3×8 returns 24.
- RST pulsed asynchronously mid-DIV_RUN: all outputs zero immediately without a clock edge, state IDLE, MDU_STALL=0.
